// File: rtl/riscv_pkg.sv
// Shared RISC-V register file constants and the register address type.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int ADDR = 5;
  typedef logic [ADDR-1:0] regaddr_t;
endpackage

// File: rtl/register_file_if.sv
// Read/write bundle between decode/writeback and the register array.
interface register_file_if #(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter int ADDR = riscv_pkg::ADDR
) ();
  logic [ADDR-1:0] rs1_addr;
  logic [ADDR-1:0] rs2_addr;
  logic [XLEN-1:0] data_out_rs1;
  logic [XLEN-1:0] data_out_rs2;
  logic            write_en;
  logic [ADDR-1:0] rd_addr;
  logic [XLEN-1:0] rd_data;

  modport register_file (
    input  rs1_addr, rs2_addr, write_en, rd_addr, rd_data,
    output data_out_rs1, data_out_rs2
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on
// writeback, wiped by flush. REGFILE_BYPASS_EN hides a bit being written back.
module regfile_scoreboard #(
  parameter int ADDR = riscv_pkg::ADDR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_en,
  input  logic [ADDR-1:0] issue_rd,
  input  logic            write_en,
  input  logic [ADDR-1:0] rd_addr,
  input  logic            flush,
  input  logic [ADDR-1:0] rs1_addr,
  input  logic [ADDR-1:0] rs2_addr,
  output logic            rs1_busy,
  output logic            rs2_busy
);
  localparam int NREG = 2 ** ADDR;

  logic [NREG-1:0] r_pending;
  logic [NREG-1:0] w_pending_nxt;

  // Clear first, then set, so a same-cycle reissue keeps the newer producer
  // outstanding; flush overrides both.
  always_comb begin
    w_pending_nxt = r_pending;
    if (write_en) w_pending_nxt[rd_addr] = 1'b0;
    if (issue_en) w_pending_nxt[issue_rd] = 1'b1;
    if (flush) w_pending_nxt = '0;
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pending <= '0;
    else        r_pending <= w_pending_nxt;
  end

`ifdef REGFILE_BYPASS_EN
  logic w_hit1, w_hit2, w_iss1, w_iss2;
  assign w_hit1 = write_en && (rd_addr != '0) && (rd_addr == rs1_addr);
  assign w_hit2 = write_en && (rd_addr != '0) && (rd_addr == rs2_addr);
  assign w_iss1 = issue_en && (issue_rd == rs1_addr);
  assign w_iss2 = issue_en && (issue_rd == rs2_addr);
  assign rs1_busy = r_pending[rs1_addr] && !(w_hit1 && !w_iss1);
  assign rs2_busy = r_pending[rs2_addr] && !(w_hit2 && !w_iss2);
`else
  assign rs1_busy = r_pending[rs1_addr];
  assign rs2_busy = r_pending[rs2_addr];
`endif
endmodule

// File: rtl/riscv_regfile_array.sv
// Register storage: synchronous write, combinational read, x0 hardwired to zero.
// REGFILE_BYPASS_EN forwards same-cycle writeback data to the read ports.
module riscv_regfile_array #(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter int ADDR = riscv_pkg::ADDR
) (
  input  logic                  clk,
  input  logic                  rst_n,
  register_file_if.register_file rf
);
  localparam int NREG = 2 ** ADDR;

  logic [XLEN-1:0] r_regs [NREG];
  logic            w_wr_valid;

  assign w_wr_valid = rf.write_en && (rf.rd_addr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_wr_valid) begin
      r_regs[rf.rd_addr] <= rf.rd_data;
    end
  end

  always_comb begin
    rf.data_out_rs1 = (rf.rs1_addr == '0) ? '0 : r_regs[rf.rs1_addr];
    rf.data_out_rs2 = (rf.rs2_addr == '0) ? '0 : r_regs[rf.rs2_addr];
`ifdef REGFILE_BYPASS_EN
    if (w_wr_valid && (rf.rd_addr == rf.rs1_addr)) rf.data_out_rs1 = rf.rd_data;
    if (w_wr_valid && (rf.rd_addr == rf.rs2_addr)) rf.data_out_rs2 = rf.rd_data;
`endif
  end
endmodule

// File: rtl/riscv_regfile.sv
// RISC-V integer register file with pending-write scoreboard.
// Optional same-cycle write forwarding: define REGFILE_BYPASS_EN.
module riscv_regfile
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter int ADDR = riscv_pkg::ADDR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [ADDR-1:0] rs1_addr,
  input  logic [ADDR-1:0] rs2_addr,
  output logic [XLEN-1:0] data_out_rs1,
  output logic [XLEN-1:0] data_out_rs2,
  input  logic            write_en,
  input  logic [ADDR-1:0] rd_addr,
  input  logic [XLEN-1:0] rd_data,
  input  logic            issue_en,
  input  logic [ADDR-1:0] issue_rd,
  input  logic            flush,
  output logic            rs1_busy,
  output logic            rs2_busy
);
  register_file_if #(.XLEN(XLEN), .ADDR(ADDR)) w_rf_if ();

  assign w_rf_if.rs1_addr = rs1_addr;
  assign w_rf_if.rs2_addr = rs2_addr;
  assign w_rf_if.write_en = write_en;
  assign w_rf_if.rd_addr  = rd_addr;
  assign w_rf_if.rd_data  = rd_data;
  assign data_out_rs1     = w_rf_if.data_out_rs1;
  assign data_out_rs2     = w_rf_if.data_out_rs2;

  riscv_regfile_array #(.XLEN(XLEN), .ADDR(ADDR)) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .rf    (w_rf_if)
  );

  regfile_scoreboard #(.ADDR(ADDR)) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .issue_en (issue_en),
    .issue_rd (issue_rd),
    .write_en (write_en),
    .rd_addr  (rd_addr),
    .flush    (flush),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy)
  );
endmodule
